if_id_skid_stage: RTL and testbench
===================================

# if_id_skid_stage

Parametrised IF/ID pipeline stage replacing the plain flop pair between fetch and decode. Carries PC and instruction under a valid/ready handshake, with a two-entry skid buffer so decode back-pressure never drops or duplicates a fetched instruction. A controller flush squashes both entries to a NOP bubble. Full throughput (one transfer per cycle) while downstream is ready; all outputs registered.

## Interface
- ADDR_W, 32: PC width
- DATA_W, 32: instruction width
- NOP_INST, 32'h0000_0013: bubble instruction (addi x0,x0,0), DATA_W bits
- BUBBLE_PC, 0: PC presented with a bubble
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- flush_i  in  1  pipeline flush from ctrl
- in_valid_i  in  1  fetch presents pc/inst
- in_ready_o  out  1  stage can accept; registered (state != FULL)
- in_pc_i  in  ADDR_W  fetched PC
- in_inst_i  in  DATA_W  fetched instruction
- out_valid_o  out  1  decode entry valid
- out_ready_i  in  1  decode accepts
- out_pc_o  out  ADDR_W  PC to decode
- out_inst_o  out  DATA_W  instruction to decode

## Operation
- in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- Storage: main entry (drives outputs) and skid entry; each holds {pc, inst}.
- States: EMPTY (neither valid), ONE (main valid), FULL (main+skid valid).
- EMPTY: in_fire -> ONE, main <= input.
- ONE: in_fire & out_fire -> ONE, main <= input; in_fire & !out_fire -> FULL, skid <= input; !in_fire & out_fire -> EMPTY; else hold.
- FULL: in_ready_o = 0; out_fire -> ONE, main <= skid; else hold.
- Leaving main empty (-> EMPTY) loads main with {BUBBLE_PC, NOP_INST}; outputs never show stale data while out_valid_o = 0.
- flush_i: highest priority; next state EMPTY, main <= bubble, skid cleared, regardless of in_fire/out_fire that cycle. An input transfer that fires in a flush cycle is consumed and discarded (ctrl refetches).
- Stall: out_valid_o = 1 and out_ready_i = 0 holds main bit-exact indefinitely.
- Upstream must keep in_pc_i/in_inst_i stable while in_valid_i & !in_ready_o (not checked here).

## Timing
- Reset (rst high at edge): state EMPTY; out_valid_o = 0, out_pc_o = BUBBLE_PC, out_inst_o = NOP_INST, in_ready_o = 1. rst overrides flush and all transfers.
- Latency: input accepted at edge N appears on outputs after edge N (1 cycle), out_valid_o = 1.
- in_ready_o falls the cycle after the edge entering FULL; rises the cycle after the edge leaving FULL. No combinational path from out_ready_i to in_ready_o.
- flush_i at edge N: out_valid_o = 0, bubble on outputs after N; in_ready_o = 1 after N.
- flush_i has no combinational effect on outputs; out_valid_o during the flush cycle is the pre-flush value.
- Throughput: out_ready_i held 1 -> one transfer per cycle sustained, state never FULL.

## Structure
- Shared package/define file: NOP_INST constant (`INST_NOP`), default ADDR_W/DATA_W (`WORD_WIDTH`), state encoding localparams EMPTY/ONE/FULL (2 bits).
- One sub-module: s_en_dff (width param, enable, synchronous clear to a load value), instantiated for main and skid entries; FSM and steering muxes in the top.
- Target 150-250 lines RTL.

## Test plan
- Reset: rst high 2 cycles, then low -> out_valid_o=0, out_inst_o=32'h00000013, out_pc_o=0, in_ready_o=1.
- Streaming: feed pc 0x0,0x4,0x8,0xC with out_ready_i=1 -> same pairs on outputs, each one cycle later, no gaps, in_ready_o stays 1.
- Back-pressure: feed 0x100/0x104/0x108, drop out_ready_i after 0x100 accepted -> 0x104 in main, 0x108 in skid, in_ready_o=0; raise out_ready_i -> 0x104 then 0x108 delivered in order, no loss/duplicate.
- Flush while FULL: state FULL with 0x200/0x204, assert flush_i one cycle -> next cycle out_valid_o=0, NOP/0 on outputs, in_ready_o=1; following input 0x300 appears one cycle later.
- Flush and input same cycle: in_valid_i=1 pc 0x400 with flush_i=1 -> 0x400 discarded, stage EMPTY next cycle.
- Random valid/ready (10k cycles) against a scoreboard queue -> order preserved, pc/inst match, no output change while stalled.

Source files
------------

// File: rtl/if_id_skid_stage_pkg.sv
// Shared constants and state encoding for the IF/ID skid-buffered pipeline stage.
package if_id_skid_stage_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam logic [31:0] INST_NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

endpackage

// File: rtl/if_id_skid_stage_s_en_dff.sv
// Enabled register with a synchronous clear that loads a supplied value.
module s_en_dff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] clr_val,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear wins over enable so a squash can never be overwritten by a load.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= clr_val;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage: valid/ready handshake with a two-entry skid buffer and flush-to-bubble.
module if_id_skid_stage
    import if_id_skid_stage_pkg::*;
#(
    parameter int unsigned        ADDR_W    = WORD_WIDTH,
    parameter int unsigned        DATA_W    = WORD_WIDTH,
    parameter logic [DATA_W-1:0]  NOP_INST  = DATA_W'(INST_NOP),
    parameter logic [ADDR_W-1:0]  BUBBLE_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [ADDR_W-1:0] in_pc_i,
    input  logic [DATA_W-1:0] in_inst_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] out_pc_o,
    output logic [DATA_W-1:0] out_inst_o
);

    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
    localparam logic [ENTRY_W-1:0] BUBBLE = {BUBBLE_PC, NOP_INST};

    stage_state_e        state_q, state_d;
    logic [ENTRY_W-1:0]  main_q, skid_q, main_d, in_entry;
    logic                main_en, skid_en, main_clr, skid_clr;
    logic                in_fire, out_fire;

    // Handshake outputs come straight from the state register: no path from out_ready_i.
    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_o & out_ready_i;
    assign in_entry    = {in_pc_i, in_inst_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = in_entry;
        main_en = 1'b0;
        skid_en = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_en = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_en = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                    main_en = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (rst || flush_i) begin
            state_d = EMPTY;
        end
    end

    // Any entry that will not be valid next cycle is reloaded with the bubble.
    assign main_clr = (state_d == EMPTY);
    assign skid_clr = (state_d != FULL);

    s_en_dff #(.WIDTH(ENTRY_W)) u_main (
        .clk     (clk),
        .clr     (main_clr),
        .clr_val (BUBBLE),
        .en      (main_en),
        .d       (main_d),
        .q       (main_q)
    );

    s_en_dff #(.WIDTH(ENTRY_W)) u_skid (
        .clk     (clk),
        .clr     (skid_clr),
        .clr_val (BUBBLE),
        .en      (skid_en),
        .d       (in_entry),
        .q       (skid_q)
    );

    assign out_pc_o   = main_q[ENTRY_W-1:DATA_W];
    assign out_inst_o = main_q[DATA_W-1:0];

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Self-checking bench for if_id_skid_stage: directed scenarios plus random valid/ready against a queue model.
module tb_if_id_skid_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    if_id_skid_stage #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .NOP_INST  (32'h0000_0013),
        .BUBBLE_PC (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_pc_i     (in_pc),
        .in_inst_i   (in_inst),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_pc_o    (out_pc),
        .out_inst_o  (out_inst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a bounded FIFO of capacity 2 whose ready/valid reflect occupancy at the start of the cycle.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;
    ent_t mq[$];
    int   m_size;
    bit   m_in_fire = 1'b0;

    always @(posedge clk) begin
        m_size    = mq.size();
        m_in_fire = in_valid && (m_size < 2);
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (m_size > 0 && out_ready) void'(mq.pop_front());
            if (m_in_fire) mq.push_back('{pc: in_pc, inst: in_inst});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
            chk("model_in_ready", {31'b0, in_ready}, {31'b0, mq.size() < 2});
            chk("model_out_pc", out_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
            chk("model_out_inst", out_inst, (mq.size() > 0) ? mq[0].inst : 32'h0000_0013);
        end
    end

    task automatic step(input bit v, input logic [31:0] pc, input bit rdy, input bit fl);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = ~pc;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input bit v, input logic [31:0] pc,
                              input logic [31:0] inst, input bit rdy);
        chk({name, "_valid"}, {31'b0, out_valid}, {31'b0, v});
        chk({name, "_pc"}, out_pc, pc);
        chk({name, "_inst"}, out_inst, inst);
        chk({name, "_ready"}, {31'b0, in_ready}, {31'b0, rdy});
    endtask

    logic [31:0] next_pc;

    initial begin
        rst = 1'b1;
        step(0, 32'h0, 0, 0);
        step(0, 32'h0, 0, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        expect_out("reset", 0, 32'h0, 32'h0000_0013, 1);

        // Streaming
        step(1, 32'h0, 1, 0);  expect_out("stream0", 1, 32'h0, 32'hFFFF_FFFF, 1);
        step(1, 32'h4, 1, 0);  expect_out("stream4", 1, 32'h4, 32'hFFFF_FFFB, 1);
        step(1, 32'h8, 1, 0);  expect_out("stream8", 1, 32'h8, 32'hFFFF_FFF7, 1);
        step(1, 32'hC, 1, 0);  expect_out("streamC", 1, 32'hC, 32'hFFFF_FFF3, 1);
        step(0, 32'h0, 1, 0);  expect_out("stream_end", 0, 32'h0, 32'h0000_0013, 1);

        // Back-pressure
        step(1, 32'h100, 1, 0); expect_out("bp100", 1, 32'h100, 32'hFFFF_FEFF, 1);
        step(1, 32'h104, 1, 0); expect_out("bp104", 1, 32'h104, 32'hFFFF_FEFB, 1);
        step(1, 32'h108, 0, 0); expect_out("bp_full", 1, 32'h104, 32'hFFFF_FEFB, 0);
        step(1, 32'h108, 0, 0); expect_out("bp_stall", 1, 32'h104, 32'hFFFF_FEFB, 0);
        step(0, 32'h0, 1, 0);   expect_out("bp_drain104", 1, 32'h108, 32'hFFFF_FEF7, 1);
        step(0, 32'h0, 1, 0);   expect_out("bp_drain108", 0, 32'h0, 32'h0000_0013, 1);

        // Flush while FULL
        step(1, 32'h200, 0, 0); expect_out("fl200", 1, 32'h200, 32'hFFFF_FDFF, 1);
        step(1, 32'h204, 0, 0); expect_out("fl_full", 1, 32'h200, 32'hFFFF_FDFF, 0);
        step(0, 32'h0, 0, 1);   expect_out("fl_flushed", 0, 32'h0, 32'h0000_0013, 1);
        step(1, 32'h300, 1, 0); expect_out("fl300", 1, 32'h300, 32'hFFFF_FCFF, 1);
        step(0, 32'h0, 1, 0);   expect_out("fl_idle", 0, 32'h0, 32'h0000_0013, 1);

        // Flush with simultaneous input
        step(1, 32'h400, 1, 1); expect_out("fl400", 0, 32'h0, 32'h0000_0013, 1);
        step(0, 32'h0, 1, 0);   expect_out("fl400_gone", 0, 32'h0, 32'h0000_0013, 1);

        // Random valid/ready; fetch holds pc/inst until it is accepted.
        next_pc = 32'h1000;
        in_pc   = next_pc;
        in_inst = $urandom;
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 60);
            flush     = ($urandom_range(0, 99) < 2);
            @(posedge clk);
            #1;
            if (m_in_fire) begin
                next_pc = next_pc + 32'd4;
                in_pc   = next_pc;
                in_inst = $urandom;
            end
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        expect_out("final_drain", 0, 32'h0, 32'h0000_0013, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
